// File: rtl/rep_code_pkg.sv
// Shared types and sizing helpers for the repetition-code transmitter.
// REP_CODE_PARITY_EN adds one even-parity bit to every frame.
package rep_code_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam int DATA_W_DEF = 8;
    localparam int REP_DEF    = 16;

    function automatic int frame_bits(input int data_w);
`ifdef REP_CODE_PARITY_EN
        return data_w + 1;
`else
        return data_w;
`endif
    endfunction

    // Counter width with a floor of one bit so degenerate sizes still elaborate.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rep_code_rep_counter.sv
// Modulo-REP slot counter with enable, synchronous clear and a wrap pulse
// that tells the transmitter when the current bit has been held REP slots.
module rep_code_rep_counter
    import rep_code_pkg::*;
#(
    parameter int REP   = REP_DEF,
    parameter int CNT_W = cnt_w(REP_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o,
    output logic             wrap_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REP - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == CNT_LAST);
    assign wrap_o = en_i & last_o;

    // Clear wins over enable so a back-to-back load restarts at slot 0.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)       cnt_d = '0;
        else if (wrap_o) cnt_d = '0;
        else if (en_i)   cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/rep_code_tx.sv
// Repetition-code serial transmitter: MSB-first, each bit held REP enabled slots.
// Define REP_CODE_PARITY_EN to append a repeated even-parity bit to each frame.
module rep_code_tx
    import rep_code_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REP    = REP_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              tx_ce,
    output logic              tx_bit,
    output logic              tx_valid,
    output logic              tx_first,
    output logic              tx_last
);

    localparam int FRAME_BITS = frame_bits(DATA_W);
    localparam int REP_W      = cnt_w(REP);
    localparam int BIT_W      = cnt_w(FRAME_BITS);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    state_e                  state_q, state_d;
    logic [FRAME_BITS-1:0]   shreg_q, shreg_d, load_val;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [REP_W-1:0]        rep_cnt;
    logic                    rep_last, rep_wrap;
    logic                    sending, last_slot, accept;

    assign sending   = (state_q == SEND);
    assign last_slot = sending & (bit_cnt_q == BIT_LAST) & rep_last;
    assign accept    = in_valid & in_ready;

`ifdef REP_CODE_PARITY_EN
    assign load_val = {in_data, ^in_data};
`else
    assign load_val = in_data;
`endif

    rep_code_rep_counter #(
        .REP   (REP),
        .CNT_W (REP_W)
    ) u_rep_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (sending & tx_ce),
        .clr_i  (accept),
        .cnt_o  (rep_cnt),
        .last_o (rep_last),
        .wrap_o (rep_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SEND;
            SEND:    if (last_slot & tx_ce) state_d = accept ? SEND : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The final wrap clears bit_cnt explicitly so it never rolls past FRAME_BITS-1.
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        if (accept) begin
            shreg_d   = load_val;
            bit_cnt_d = '0;
        end else if (rep_wrap) begin
            shreg_d   = shreg_q << 1;
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
        end
    end

    always_comb begin
        in_ready = (state_q == IDLE) | (last_slot & tx_ce);
        tx_valid = sending;
        tx_bit   = sending & shreg_q[FRAME_BITS-1];
        tx_first = sending & (bit_cnt_q == '0) & (rep_cnt == '0);
        tx_last  = last_slot;
    end

endmodule

// File: tb/tb_rep_code_tx.sv
// Scoreboard bench for rep_code_tx: expected slots are queued on predicted
// acceptance and retired on every enabled slot seen on the line.
module tb_rep_code_tx;
    import rep_code_pkg::*;

    localparam int DATA_W = 8;
    localparam int REP    = 16;
`ifdef REP_CODE_PARITY_EN
    localparam int FB = DATA_W + 1;
`else
    localparam int FB = DATA_W;
`endif
    localparam int SLOTS = FB * REP;

    typedef struct packed {
        logic b;
        logic f;
        logic l;
    } slot_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              tx_ce;
    logic              tx_bit, tx_valid, tx_first, tx_last;

    int    n_chk = 0;
    int    n_err = 0;
    slot_t q[$];
    logic  cap[$];
    int    acc_cnt    = 0;
    int    vld_cycles = 0;
    int    slot_cnt   = 0;
    logic  mon_en     = 1'b0;
    logic  ce_toggle  = 1'b0;

    rep_code_tx #(.DATA_W(DATA_W), .REP(REP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .tx_ce    (tx_ce),
        .tx_bit   (tx_bit),
        .tx_valid (tx_valid),
        .tx_first (tx_first),
        .tx_last  (tx_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [DATA_W-1:0] d);
        logic [FB-1:0] bits;
        slot_t s;
`ifdef REP_CODE_PARITY_EN
        bits = {d, ^d};
`else
        bits = d;
`endif
        for (int b = 0; b < FB; b++) begin
            for (int r = 0; r < REP; r++) begin
                s.b = bits[FB-1-b];
                s.f = (b == 0) && (r == 0);
                s.l = (b == FB - 1) && (r == REP - 1);
                q.push_back(s);
            end
        end
    endtask

    // Monitor samples on the falling edge; inputs change 1 time unit after rising edges.
    always @(negedge clk) begin
        logic exp_ready;
        if (mon_en) begin
            exp_ready = (q.size() == 0) ? 1'b1 : (q[0].l && tx_ce);
            check("in_ready", in_ready, exp_ready);
            check("tx_valid", tx_valid, q.size() != 0);
            if (q.size() != 0) begin
                check("tx_bit", tx_bit, q[0].b);
                check("tx_first", tx_first, q[0].f);
                check("tx_last", tx_last, q[0].l);
                vld_cycles++;
                if (tx_ce) begin
                    slot_cnt++;
                    cap.push_back(tx_bit);
                    void'(q.pop_front());
                end
            end else begin
                check("idle_bit", tx_bit, 1'b0);
                check("idle_first", tx_first, 1'b0);
                check("idle_last", tx_last, 1'b0);
            end
            if (in_valid && exp_ready) begin
                push_frame(in_data);
                acc_cnt++;
            end
        end
    end

    initial begin
        tx_ce = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_ce = ce_toggle ? ~tx_ce : 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int target);
        int n = 0;
        while (acc_cnt < target && n < 2000) begin
            step();
            n++;
        end
        check("accept_timeout", acc_cnt >= target, 1'b1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 3000) begin
            step();
            n++;
        end
        step();
        step();
        check("frame_timeout", q.size() == 0, 1'b1);
    endtask

    task automatic clear_stats();
        vld_cycles = 0;
        slot_cnt   = 0;
        cap.delete();
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        int target;
        target   = acc_cnt + 1;
        in_valid = 1'b1;
        in_data  = d;
        wait_acc(target);
        in_valid = 1'b0;
        in_data  = DATA_W'($urandom);
    endtask

    initial begin
        logic [DATA_W-1:0] rec;
        int ones, base, n;
        logic v;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #12;
        check("rst_ready", in_ready, 1'b1);
        check("rst_valid", tx_valid, 1'b0);
        check("rst_bit", tx_bit, 1'b0);
        check("rst_first", tx_first, 1'b0);
        check("rst_last", tx_last, 1'b0);
        step();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (3) step();

        // Single frame at full rate.
        clear_stats();
        send(8'hA5);
        wait_idle();
        check("a5_cycles", vld_cycles, SLOTS);
        check("a5_slots", slot_cnt, SLOTS);

        // Back-to-back frames with in_valid held across the boundary.
        clear_stats();
        in_valid = 1'b1;
        in_data  = 8'hFF;
        base     = acc_cnt;
        wait_acc(base + 1);
        in_data  = 8'h00;
        wait_acc(base + 2);
        in_valid = 1'b0;
        wait_idle();
        check("b2b_cycles", vld_cycles, 2 * SLOTS);
        check("b2b_slots", slot_cnt, 2 * SLOTS);

        // Half-rate bit-slot enable.
        clear_stats();
        ce_toggle = 1'b1;
        repeat (4) step();
        send(8'h80);
        wait_idle();
        ce_toggle = 1'b0;
        check("ce_cycles", vld_cycles, 2 * SLOTS);
        check("ce_slots", slot_cnt, SLOTS);

        // Asynchronous abort mid-frame.
        clear_stats();
        send(8'h5A);
        n = 0;
        while (slot_cnt < 40 && n < 500) begin
            step();
            n++;
        end
        check("pre_abort_slots", slot_cnt, 40);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        check("abort_valid", tx_valid, 1'b0);
        check("abort_ready", in_ready, 1'b1);
        check("abort_bit", tx_bit, 1'b0);
        check("abort_first", tx_first, 1'b0);
        check("abort_last", tx_last, 1'b0);
        repeat (3) step();
        rst_n = 1'b1;
        clear_stats();
        repeat (20) step();
        check("post_abort_idle", vld_cycles, 0);

        // Majority-vote recovery with one slot flipped per group.
        clear_stats();
        send(8'h3C);
        wait_idle();
        check("mv_len", cap.size(), SLOTS);
        rec = '0;
        if (cap.size() == SLOTS) begin
            for (int g = 0; g < FB; g++) begin
                ones = 0;
                for (int k = 0; k < REP; k++) begin
                    v = cap[g * REP + k];
                    if (k == (g % REP)) v = ~v;
                    ones += int'(v);
                end
                if (g < DATA_W) rec[DATA_W-1-g] = (ones > REP / 2);
`ifdef REP_CODE_PARITY_EN
                else check("mv_parity", ones > REP / 2, ^8'h3C);
`endif
            end
        end
        check("mv_word", rec, 8'h3C);

`ifdef REP_CODE_PARITY_EN
        clear_stats();
        send(8'h07);
        wait_idle();
        check("par_slots", slot_cnt, 144);
        ones = 0;
        if (cap.size() == 144)
            for (int k = 128; k < 144; k++) ones += int'(cap[k]);
        check("par_tail_ones", ones, 16);
`endif

        // A few random words, some back-to-back.
        for (int i = 0; i < 4; i++) begin
            clear_stats();
            in_valid = 1'b1;
            in_data  = DATA_W'($urandom);
            base     = acc_cnt;
            wait_acc(base + 1);
            in_data  = DATA_W'($urandom);
            wait_acc(base + 2);
            in_valid = 1'b0;
            in_data  = DATA_W'($urandom);
            wait_idle();
            check("rnd_slots", slot_cnt, 2 * SLOTS);
        end

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rep_code_tx.md
# rep_code_tx

Repetition-code serial transmitter: the sending end of the majority-vote link. Each accepted data word is serialized one bit at a time, and every bit is held on the line for REP consecutive bit slots. A receiver-side majority voter (REP = 16, decision threshold > 8 ones) can then recover each bit despite isolated line errors. The block sits between a word-level producer (valid/ready) and the serial line driver.

## Interface
- DATA_W, 8, data word width in bits (≥ 1)
- REP, 16, repetitions per bit (≥ 1; 16 matches the 16-input voter)

- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer has a word on in_data
- in_data  input  DATA_W  word to transmit, MSB sent first
- in_ready  output  1  block accepts in_data this cycle
- tx_ce  input  1  bit-slot enable; the line advances only when tx_ce = 1
- tx_bit  output  1  serial line value
- tx_valid  output  1  a frame is on the line
- tx_first  output  1  first slot of the frame (first repetition of the MSB)
- tx_last  output  1  final slot of the frame

## Operation
- FSM has two states, IDLE and SEND. Reset enters IDLE.
- IDLE: in_ready = 1. On in_valid & in_ready the block latches in_data into the shift register, clears rep_cnt and bit_cnt, and goes to SEND.
- SEND: tx_valid = 1 and tx_bit = shreg[MSB].
  - On each cycle with tx_ce = 1, rep_cnt increments.
  - When rep_cnt = REP-1 with tx_ce = 1: rep_cnt wraps to 0, the shift register shifts left, and bit_cnt increments.
- Frame length is FRAME_BITS × REP enabled slots, where FRAME_BITS = DATA_W (or DATA_W+1 with parity).
- tx_first = SEND & bit_cnt = 0 & rep_cnt = 0.
- tx_last = SEND & bit_cnt = FRAME_BITS-1 & rep_cnt = REP-1.
- tx_ce = 0 freezes all counters and the shift register. tx_bit, tx_first and tx_last hold their values.
- in_ready is also 1 in SEND when tx_last & tx_ce (back-to-back acceptance).
  - If a word is accepted then, it loads and the FSM stays in SEND with counters cleared, so there is no idle slot.
  - Otherwise the FSM returns to IDLE.
- in_ready depends only on state, counters and tx_ce. It never depends on in_valid.
- in_data is sampled only on the accepting edge and is ignored at all other times.
- Counter widths: rep_cnt is $clog2(REP) bits and bit_cnt is $clog2(FRAME_BITS) bits, both with a minimum of 1. Counters wrap only through the explicit clear; they never overflow.
- REP = 1 degenerates to a plain serializer: every enabled slot advances a bit.

## Timing
- Reset values: in_ready = 1, tx_bit = 0, tx_valid = 0, tx_first = 0, tx_last = 0. The shift register and counters reset to 0.
- Acceptance at edge N: tx_valid = 1, tx_first = 1 and tx_bit = in_data[MSB] are visible after edge N.
- With tx_ce held at 1, the frame occupies exactly FRAME_BITS × REP cycles after the accepting edge. tx_last is high in the final cycle.
- Without back-to-back acceptance, tx_valid drops after the edge that ends the final slot.
- Reset asserted mid-frame: the frame is aborted immediately and asynchronously. Outputs take their reset values, and no partial word resumes after reset releases.
- tx_ce = 0 during IDLE has no effect. Acceptance does not require tx_ce.

## Configuration
- REP_CODE_PARITY_EN defined: after the DATA_W data bits, one even-parity bit (XOR of the latched word) is sent. It is repeated REP times, so FRAME_BITS = DATA_W+1. tx_last marks the final parity slot.
- REP_CODE_PARITY_EN undefined: no parity bit is sent and FRAME_BITS = DATA_W.

## Structure
- Package rep_code_pkg holds:
  - the state enum (IDLE, SEND)
  - the default DATA_W and REP
  - a localparam function computing FRAME_BITS from DATA_W and the parity macro
- One sub-module: rep_code_rep_counter. It is a modulo-REP counter with enable, synchronous clear and a wrap pulse. It drives the bit-advance of the top level.

## Test plan
- DATA_W = 8, REP = 16, tx_ce = 1, send 0xA5 → 128 slots, each group of 16 equal, bit groups 1,0,1,0,0,1,0,1. tx_first is at slot 0 only, tx_last at slot 127 only, in_ready is 0 during slots 0–126.
- Back-to-back 0xFF then 0x00 with in_valid held → 256 contiguous tx_valid cycles. The line is 128 ones then 128 zeros, and the second acceptance happens in the tx_last cycle of the first frame.
- tx_ce toggling 1,0,1,0 while sending 0x80 → the frame takes 256 cycles, tx_bit holds during tx_ce = 0 cycles, and the slot count stays 128.
- rst_n pulsed low during slot 40 of a frame → outputs go to reset values immediately. After release, in_ready = 1 and tx_valid = 0 until a new acceptance.
- With REP_CODE_PARITY_EN, send 0x07 → 144 slots, the last 16 slots are 1 (three ones give odd weight, so parity = 1), and tx_last is at slot 143.
- Each received 16-slot group is fed into the majority voter with one slot flipped per group → the recovered word equals the sent word for 0x3C.
